// File: rtl/decoder.sv
// RV32I field decoder: splits an instruction word into opcode, register indices, function code and raw immediates.
// Latency: 1 cycle; the decode is captured on the rising clk edge with en=1 and held while en=0.
// Backpressure: none; en gates capture, and async active-low rst clears every output.
module decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] instr,
    output logic [6:0]  op,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [9:0]  func,
    output logic [11:0] imms,
    output logic [19:0] imml,
    output logic        illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [6:0]  op_d,  op_q;
    logic [4:0]  rs1_d, rs1_q;
    logic [4:0]  rs2_d, rs2_q;
    logic [4:0]  rd_d,  rd_q;
    logic [9:0]  func_d, func_q;
    logic [11:0] imms_d, imms_q;
    logic [19:0] imml_d, imml_q;
    logic        illegal_d, illegal_q;

    logic [6:0] opc;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opc    = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Combinational decode of the presented word; fields not used by a format stay zero.
    always_comb begin
        op_d      = opc;
        rs1_d     = '0;
        rs2_d     = '0;
        rd_d      = '0;
        func_d    = '0;
        imms_d    = '0;
        imml_d    = '0;
        illegal_d = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal_d = 1'b1;
        end else begin
            case (opc)
                OPC_OP: begin
                    rs1_d  = instr[19:15];
                    rs2_d  = instr[24:20];
                    rd_d   = instr[11:7];
                    func_d = {funct7, funct3};
                end
                OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_FENCE, OPC_SYSTEM: begin
                    rs1_d  = instr[19:15];
                    rd_d   = instr[11:7];
                    imms_d = instr[31:20];
                    // Shift-immediates carry funct7 (arith/logical select) in the upper immediate bits.
                    if (opc == OPC_OP_IMM && (funct3 == 3'b001 || funct3 == 3'b101))
                        func_d = {funct7, funct3};
                    else
                        func_d = {7'b0, funct3};
                end
                OPC_STORE: begin
                    rs1_d  = instr[19:15];
                    rs2_d  = instr[24:20];
                    func_d = {7'b0, funct3};
                    imms_d = {instr[31:25], instr[11:7]};
                end
                OPC_BRANCH: begin
                    rs1_d  = instr[19:15];
                    rs2_d  = instr[24:20];
                    func_d = {7'b0, funct3};
                    imms_d = {instr[31], instr[7], instr[30:25], instr[11:8]};
                end
                OPC_LUI, OPC_AUIPC: begin
                    rd_d   = instr[11:7];
                    imml_d = instr[31:12];
                end
                OPC_JAL: begin
                    rd_d   = instr[11:7];
                    imml_d = {instr[31], instr[19:12], instr[20], instr[30:21]};
                end
                default: illegal_d = 1'b1;
            endcase
        end
    end

    // Output registers: cleared asynchronously by rst, loaded only when en is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            func_q    <= '0;
            imms_q    <= '0;
            imml_q    <= '0;
            illegal_q <= 1'b0;
        end else if (en) begin
            op_q      <= op_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            func_q    <= func_d;
            imms_q    <= imms_d;
            imml_q    <= imml_d;
            illegal_q <= illegal_d;
        end
    end

    assign op      = op_q;
    assign rs1     = rs1_q;
    assign rs2     = rs2_q;
    assign rd      = rd_q;
    assign func    = func_q;
    assign imms    = imms_q;
    assign imml    = imml_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder: hand-computed RV32I vectors, hold, illegal and async reset cases.
// Latency: outputs checked 1 ns after the capturing rising edge.
// Backpressure: none; en is driven directly.
module tb_decoder;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [9:0]  func;
    logic [11:0] imms;
    logic [19:0] imml;
    logic        illegal;

    int vectors = 0;
    int errs    = 0;

    decoder dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .instr   (instr),
        .op      (op),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd),
        .func    (func),
        .imms    (imms),
        .imml    (imml),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic [6:0]  e_op,  input logic [4:0]  e_rs1,
                           input logic [4:0]  e_rs2, input logic [4:0]  e_rd,
                           input logic [9:0]  e_func, input logic [11:0] e_imms,
                           input logic [19:0] e_imml, input logic       e_ill);
        chk({tag, ".op"},      32'(op),      32'(e_op));
        chk({tag, ".rs1"},     32'(rs1),     32'(e_rs1));
        chk({tag, ".rs2"},     32'(rs2),     32'(e_rs2));
        chk({tag, ".rd"},      32'(rd),      32'(e_rd));
        chk({tag, ".func"},    32'(func),    32'(e_func));
        chk({tag, ".imms"},    32'(imms),    32'(e_imms));
        chk({tag, ".imml"},    32'(imml),    32'(e_imml));
        chk({tag, ".illegal"}, 32'(illegal), 32'(e_ill));
    endtask

    // Present a word on the falling edge, then sample just after the next rising edge.
    task automatic apply(input logic e, input logic [31:0] w);
        @(negedge clk);
        en    = e;
        instr = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b0;
        en    = 1'b0;
        instr = 32'h0;
        #2;
        chk_all("reset_init", 7'h00, 5'd0, 5'd0, 5'd0, 10'h000, 12'h000, 20'h00000, 1'b0);

        // Edges while reset is held must not capture anything.
        en    = 1'b1;
        instr = 32'h00500093;
        @(posedge clk);
        #1;
        chk_all("reset_hold", 7'h00, 5'd0, 5'd0, 5'd0, 10'h000, 12'h000, 20'h00000, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        apply(1'b1, 32'h00500093); // addi x1,x0,5
        chk_all("addi", 7'h13, 5'd0, 5'd0, 5'd1, 10'h000, 12'h005, 20'h00000, 1'b0);

        apply(1'b1, 32'h402081B3); // sub x3,x1,x2
        chk_all("sub", 7'h33, 5'd1, 5'd2, 5'd3, 10'h100, 12'h000, 20'h00000, 1'b0);

        apply(1'b1, 32'h0020A423); // sw x2,8(x1)
        chk_all("sw", 7'h23, 5'd1, 5'd2, 5'd0, 10'h002, 12'h008, 20'h00000, 1'b0);

        apply(1'b1, 32'h123452B7); // lui x5,0x12345
        chk_all("lui", 7'h37, 5'd0, 5'd0, 5'd5, 10'h000, 12'h000, 20'h12345, 1'b0);

        apply(1'b1, 32'hFFDFF0EF); // jal x1,-4
        chk_all("jal", 7'h6F, 5'd0, 5'd0, 5'd1, 10'h000, 12'h000, 20'hFFFFE, 1'b0);

        apply(1'b1, 32'h40315093); // srai x1,x2,3: funct7 kept in func
        chk_all("srai", 7'h13, 5'd2, 5'd0, 5'd1, 10'h105, 12'h403, 20'h00000, 1'b0);

        apply(1'b1, 32'h00208463); // beq x1,x2,+8 -> imm[12:1]=4
        chk_all("beq", 7'h63, 5'd1, 5'd2, 5'd0, 10'h000, 12'h004, 20'h00000, 1'b0);

        apply(1'b1, 32'h00500092); // low bits 10: compressed space, not supported
        chk_all("ill_lowbits", 7'h12, 5'd0, 5'd0, 5'd0, 10'h000, 12'h000, 20'h00000, 1'b1);

        apply(1'b1, 32'h0020807B); // unlisted opcode 1111011
        chk_all("ill_opc", 7'h7B, 5'd0, 5'd0, 5'd0, 10'h000, 12'h000, 20'h00000, 1'b1);

        apply(1'b1, 32'hFFFFFFFF);
        chk_all("ill_ones", 7'h7F, 5'd0, 5'd0, 5'd0, 10'h000, 12'h000, 20'h00000, 1'b1);

        apply(1'b0, 32'h402081B3); // en=0: must hold the illegal decode
        chk_all("hold", 7'h7F, 5'd0, 5'd0, 5'd0, 10'h000, 12'h000, 20'h00000, 1'b1);

        apply(1'b1, 32'h402081B3);
        chk_all("sub_again", 7'h33, 5'd1, 5'd2, 5'd3, 10'h100, 12'h000, 20'h00000, 1'b0);

        // Async reset between edges: outputs clear without any clock edge.
        en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 7'h00, 5'd0, 5'd0, 5'd0, 10'h000, 12'h000, 20'h00000, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        apply(1'b1, 32'h123452B7);
        chk_all("post_rst_lui", 7'h37, 5'd0, 5'd0, 5'd5, 10'h000, 12'h000, 20'h12345, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
